keypad_matrix_scan: RTL and testbench

Parametrised keypad matrix scanner for the mole-game platform. It drives one-hot column strobes, samples the row inputs and debounces every key independently. Its outputs are a level per key, a one-cycle press pulse per key, and an encoded code/valid pair for the lowest-numbered new press. It sits between the board keypad pins and the game-scoring logic, and supersedes the fixed 3×2 scanner.

---
 rtl/keypad_matrix_scan.sv | 122 ++++++++++++
 tb/tb_keypad_matrix_scan.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scan.sv
// keypad_matrix_scan: parametrised keypad matrix scanner with per-key debounce and press encoding
//
// Drives one-hot column strobes, holds each column for SETTLE cycles, samples
// the rows into a raw image, and once per frame debounces every key on its own.
//
// Optional feature: define KEYPAD_REPEAT_EN to add per-key auto-repeat. A held
// key then pulses key_press again every REPEAT_FRAMES frames.
//
// Ports:
//   key_clk    scan clock, rising edge
//   RESET      asynchronous, active-high reset
//   key_row    row sense lines, active-high (bit r = row r)
//   key_col    one-hot column strobe, active-high
//   key_data   debounced level per key, key k = r*COLS + c
//   key_press  one-cycle pulse per key on a debounced press
//   key_valid  one-cycle pulse whenever key_press is nonzero
//   key_code   index of the lowest key_press bit; holds its value otherwise
module keypad_matrix_scan #(
  parameter int COLS = 3,
  parameter int ROWS = 2,
  parameter int SETTLE = 2,
  parameter int DEBOUNCE = 4,
  parameter int REPEAT_FRAMES = 8
) (
  input  logic                                     key_clk,
  input  logic                                     RESET,
  input  logic [ROWS-1:0]                          key_row,
  output logic [COLS-1:0]                          key_col,
  output logic [ROWS*COLS-1:0]                     key_data,
  output logic [ROWS*COLS-1:0]                     key_press,
  output logic                                     key_valid,
  output logic [(ROWS*COLS>1 ? $clog2(ROWS*COLS) : 1)-1:0] key_code
);
  localparam int N = ROWS * COLS;
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int DW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam int BW = $clog2(DEBOUNCE + 1);
  localparam int KW = N > 1 ? $clog2(N) : 1;

  logic [CW-1:0] c;
  logic [DW-1:0] d;
  logic [N-1:0] raw;
  logic eval;
  logic [N-1:0][BW-1:0] cnt, cnt_nxt;
  logic [N-1:0] data_nxt, press_nxt;
  logic [KW-1:0] code_nxt;
  logic sample, last;

  assign sample = d == DW'(SETTLE - 1);
  assign last = c == CW'(COLS - 1);
  assign key_col = COLS'(1) << c;

  // eval marks the edge right after a frame end, when raw is complete
  always_ff @(posedge key_clk or posedge RESET)
    if (RESET) begin
      c <= '0;
      d <= '0;
      raw <= '0;
      eval <= 1'b0;
    end else begin
      eval <= sample && last;
      d <= sample ? '0 : d + 1'b1;
      if (sample) begin
        c <= last ? '0 : c + 1'b1;
        for (int r = 0; r < ROWS; r++) raw[r*COLS + int'(c)] <= key_row[r];
      end
    end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = REPEAT_FRAMES > 1 ? $clog2(REPEAT_FRAMES) : 1;
  logic [N-1:0][RW-1:0] rep, rep_nxt;
`endif

  always_comb begin
    data_nxt = key_data;
    cnt_nxt = cnt;
    for (int k = 0; k < N; k++)
      if (eval) begin
        if (raw[k] == key_data[k]) cnt_nxt[k] = '0;
        else if (cnt[k] == BW'(DEBOUNCE - 1)) begin
          data_nxt[k] = ~key_data[k];
          cnt_nxt[k] = '0;
        end else cnt_nxt[k] = cnt[k] + 1'b1;
      end
    press_nxt = data_nxt & ~key_data;
`ifdef KEYPAD_REPEAT_EN
    rep_nxt = rep;
    // repeat counts only evaluations where the key was already down and stays down
    for (int k = 0; k < N; k++)
      if (eval) begin
        if (!(key_data[k] && data_nxt[k])) rep_nxt[k] = '0;
        else if (rep[k] == RW'(REPEAT_FRAMES - 1)) begin
          rep_nxt[k] = '0;
          press_nxt[k] = 1'b1;
        end else rep_nxt[k] = rep[k] + 1'b1;
      end
`endif
    code_nxt = key_code;
    for (int k = N - 1; k >= 0; k--) if (press_nxt[k]) code_nxt = KW'(k);
  end

  always_ff @(posedge key_clk or posedge RESET)
    if (RESET) begin
      cnt <= '0;
      key_data <= '0;
      key_press <= '0;
      key_valid <= 1'b0;
      key_code <= '0;
    end else begin
      cnt <= cnt_nxt;
      key_data <= data_nxt;
      key_press <= press_nxt;
      key_valid <= |press_nxt;
      key_code <= code_nxt;
    end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge key_clk or posedge RESET)
    if (RESET) rep <= '0;
    else rep <= rep_nxt;
`endif
endmodule

// File: tb/tb_keypad_matrix_scan.sv
// tb_keypad_matrix_scan: directed self-checking bench for keypad_matrix_scan (3x2, SETTLE=2, DEBOUNCE=4)
module tb_keypad_matrix_scan;
  logic key_clk = 1'b0;
  logic RESET = 1'b1;
  logic [1:0] key_row;
  logic [2:0] key_col;
  logic [5:0] key_data, key_press;
  logic key_valid;
  logic [2:0] key_code;
  logic [5:0] keys = '0;
  logic seen;
  logic [5:0] dseen;
  int checks = 0;
  int failures = 0;
  logic [2:0] colseq [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};

  keypad_matrix_scan dut (
    .key_clk(key_clk), .RESET(RESET), .key_row(key_row), .key_col(key_col),
    .key_data(key_data), .key_press(key_press), .key_valid(key_valid), .key_code(key_code)
  );

  always #5 key_clk = ~key_clk;

  // physical matrix: a row reads high when a pressed key sits on the strobed column
  always_comb
    for (int r = 0; r < 2; r++) key_row[r] = |(keys[r*3 +: 3] & key_col);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge key_clk);
  endtask

  task automatic watch(input int n);
    repeat (n) begin
      @(negedge key_clk);
      seen |= key_valid;
      dseen |= key_data;
    end
  endtask

  task automatic do_reset();
    keys = '0;
    RESET = 1'b1;
    tick(2);
    RESET = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_col", 32'(key_col), 32'b001);
    chk("rst_outs", 32'({key_data, key_press, key_valid, key_code}), 32'd0);
    for (int i = 0; i < 12; i++) begin
      chk("scan_col", 32'(key_col), 32'(colseq[i % 6]));
      chk("scan_idle", 32'({key_data, key_press, key_valid, key_code}), 32'd0);
      tick(1);
    end

    do_reset();
    keys = 6'b010000;
    seen = 1'b0;
    dseen = '0;
    watch(24);
    chk("k4_early_valid", 32'(seen), 32'd0);
    chk("k4_early_data", 32'(dseen), 32'd0);
    tick(1);
    chk("k4_data", 32'(key_data), 32'b010000);
    chk("k4_press", 32'(key_press), 32'b010000);
    chk("k4_valid", 32'(key_valid), 32'd1);
    chk("k4_code", 32'(key_code), 32'd4);
    tick(1);
    chk("k4_press_end", 32'(key_press), 32'd0);
    chk("k4_valid_end", 32'(key_valid), 32'd0);
    chk("k4_code_hold", 32'(key_code), 32'd4);
    keys = '0;
    seen = 1'b0;
    watch(22);
    chk("k4_rel_hold", 32'(key_data), 32'b010000);
    chk("k4_rel_nopulse", 32'(seen), 32'd0);
    tick(1);
    chk("k4_rel_data", 32'(key_data), 32'd0);
    chk("k4_rel_press", 32'({key_press, key_valid}), 32'd0);

    do_reset();
    keys = 6'b000001;
    seen = 1'b0;
    dseen = '0;
    tick(19);
    keys = '0;
    watch(60);
    chk("b3_data", 32'(dseen), 32'd0);
    chk("b3_valid", 32'(seen), 32'd0);
    for (int f = 0; f < 10; f++) begin
      keys[0] = ~f[0];
      watch(6);
    end
    chk("balt_data", 32'(dseen), 32'd0);
    chk("balt_valid", 32'(seen), 32'd0);

    do_reset();
    keys = 6'b100010;
    tick(24);
    chk("sim_early", 32'({key_data, key_press}), 32'd0);
    tick(1);
    chk("sim_press", 32'(key_press), 32'b100010);
    chk("sim_valid", 32'(key_valid), 32'd1);
    chk("sim_code", 32'(key_code), 32'd1);
    chk("sim_data", 32'(key_data), 32'b100010);
    tick(1);
    chk("sim_press_end", 32'({key_press, key_valid}), 32'd0);
    chk("sim_code_hold", 32'(key_code), 32'd1);

    do_reset();
    keys = 6'b000100;
    tick(20);
    RESET = 1'b1;
    #1;
    chk("mid_rst_col", 32'(key_col), 32'b001);
    chk("mid_rst_data", 32'(key_data), 32'd0);
    tick(2);
    RESET = 1'b0;
    seen = 1'b0;
    dseen = '0;
    watch(24);
    chk("mid_early_valid", 32'(seen), 32'd0);
    chk("mid_early_data", 32'(dseen), 32'd0);
    tick(1);
    chk("mid_data", 32'(key_data), 32'b000100);
    chk("mid_press", 32'(key_press), 32'b000100);
    chk("mid_code", 32'(key_code), 32'd2);

    do_reset();
    keys = 6'b001000;
    tick(25);
    chk("rep_first", 32'(key_press), 32'b001000);
    chk("rep_first_code", 32'(key_code), 32'd3);
    seen = 1'b0;
    watch(47);
    chk("rep_gap", 32'(seen), 32'd0);
    tick(1);
`ifdef KEYPAD_REPEAT_EN
    chk("rep_second", 32'(key_press), 32'b001000);
    chk("rep_second_valid", 32'(key_valid), 32'd1);
    chk("rep_second_code", 32'(key_code), 32'd3);
`else
    chk("rep_none", 32'(key_press), 32'd0);
    chk("rep_none_valid", 32'(key_valid), 32'd0);
`endif
    chk("rep_data", 32'(key_data), 32'b001000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
